// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types for the memory port arbiter
//   state_t : arbiter FSM states (IDLE, ACCESS, WAIT)
//   rq_t    : requester IDs (RQ_IF fetch, RQ_DM load/store, RQ_LD loader)
//   DW      : memory data width
package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2} state_t;
   typedef enum logic [1:0] {RQ_IF = 2'd0, RQ_DM = 2'd1, RQ_LD = 2'd2} rq_t;
   localparam int DW = 32;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory signals of the memory port arbiter
//   fetch : if_req, if_addr -> if_gnt, if_valid, if_rdata
//   data  : dm_req, dm_we, dm_addr, dm_wdata -> dm_gnt, dm_valid, dm_rdata
//   memory: mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//   status: busy
//   loader (MEMARB_LOADER_EN only): ld_req, ld_addr, ld_wdata -> ld_gnt
//   modports: slave = arbiter side, master = requester/memory side
interface mem_port_arbiter_if import mem_port_arbiter_pkg::*; #(parameter int AW = 32);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_valid;
   logic [DW-1:0] if_rdata;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_gnt;
   logic          dm_valid;
   logic [DW-1:0] dm_rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;
`ifdef MEMARB_LOADER_EN
   logic          ld_req;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          ld_gnt;
`endif
   modport slave (
`ifdef MEMARB_LOADER_EN
      input ld_req, ld_addr, ld_wdata, output ld_gnt,
`endif
      input if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, busy
   );
   modport master (
`ifdef MEMARB_LOADER_EN
      output ld_req, ld_addr, ld_wdata, input ld_gnt,
`endif
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
      input mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational winner select for the memory port arbiter
//   if_req, dm_req, ld_req : pending requests
//   last_dm                : 1 when the data port was served last
//   pick                   : winning requester ID (meaningful only when a req is high)
//   LD_EN                  : loader present; it then beats fetch and data
module mem_arb_pick import mem_port_arbiter_pkg::*; #(parameter bit LD_EN = 1'b0) (
   input  logic if_req,
   input  logic dm_req,
   input  logic ld_req,
   input  logic last_dm,
   output rq_t  pick
);
   always_comb
      pick = (LD_EN && ld_req)  ? RQ_LD :
             (dm_req && if_req) ? (last_dm ? RQ_IF : RQ_DM) :
             dm_req             ? RQ_DM : RQ_IF;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch, load/store and an optional loader
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : mem_port_arbiter_if.slave (requester handshakes, memory port, busy)
//   RD_LATENCY : cycles from mem_en until mem_rdata is valid (1..15)
//   AW         : byte address width
//   MEMARB_LOADER_EN : when defined, adds the write-only, highest-priority loader port
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
   parameter int RD_LATENCY = 1,
   parameter int AW         = 32
) (
   input logic             clk,
   input logic             reset,
   mem_port_arbiter_if.slave bus
);
   state_t        state, next;
   rq_t           who, pick;
   logic [3:0]    cnt;
   logic          we_r, last_dm, any_req, done;
   logic [AW-1:0] addr_r;
   logic [DW-1:0] wdata_r;
   logic          ld_req;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
`ifdef MEMARB_LOADER_EN
   localparam bit LD_EN = 1'b1;
   assign ld_req     = bus.ld_req;
   assign ld_addr    = bus.ld_addr;
   assign ld_wdata   = bus.ld_wdata;
   assign bus.ld_gnt = state == ACCESS && who == RQ_LD;
`else
   localparam bit LD_EN = 1'b0;
   assign ld_req   = 1'b0;
   assign ld_addr  = '0;
   assign ld_wdata = '0;
`endif
   assign any_req = bus.if_req || bus.dm_req || ld_req;
   assign done    = state == WAIT && cnt == 4'd0;
   mem_arb_pick #(.LD_EN(LD_EN)) u_pick (
      .if_req (bus.if_req),
      .dm_req (bus.dm_req),
      .ld_req (ld_req),
      .last_dm(last_dm),
      .pick   (pick)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= next;
   always_comb begin
      next = state;
      if (state == IDLE && any_req) next = ACCESS;
      else if (state == ACCESS)     next = we_r ? IDLE : WAIT;
      else if (done)                next = IDLE;
      bus.if_gnt    = state == ACCESS && who == RQ_IF;
      bus.dm_gnt    = state == ACCESS && who == RQ_DM;
      bus.mem_en    = state == ACCESS;
      bus.mem_we    = state == ACCESS && we_r;
      bus.mem_addr  = addr_r & ~AW'(3);
      bus.mem_wdata = wdata_r;
      bus.busy      = state != IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         who          <= RQ_IF;
         cnt          <= '0;
         we_r         <= 1'b0;
         addr_r       <= '0;
         wdata_r      <= '0;
         last_dm      <= 1'b0;
         bus.if_valid <= 1'b0;
         bus.dm_valid <= 1'b0;
         bus.if_rdata <= '0;
         bus.dm_rdata <= '0;
      end else begin
         bus.if_valid <= 1'b0;
         bus.dm_valid <= 1'b0;
         if (state == IDLE && any_req) begin
            who     <= pick;
            we_r    <= pick == RQ_LD ? 1'b1 : pick == RQ_DM ? bus.dm_we : 1'b0;
            addr_r  <= pick == RQ_LD ? ld_addr : pick == RQ_DM ? bus.dm_addr : bus.if_addr;
            wdata_r <= pick == RQ_LD ? ld_wdata : bus.dm_wdata;
            // the loader is outside the fetch/data alternation
            if (pick != RQ_LD) last_dm <= pick == RQ_DM;
         end
         if (state == ACCESS) begin
            cnt <= 4'(RD_LATENCY - 1);
            // loader writes complete silently; only data stores get a valid pulse
            if (we_r && who == RQ_DM) bus.dm_valid <= 1'b1;
         end
         if (state == WAIT && !done) cnt <= cnt - 4'd1;
         if (done && who == RQ_IF) begin
            bus.if_valid <= 1'b1;
            bus.if_rdata <= bus.mem_rdata;
         end
         if (done && who != RQ_IF) begin
            bus.dm_valid <= 1'b1;
            bus.dm_rdata <= bus.mem_rdata;
         end
      end
endmodule
